branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 141 ++++++++++++++
 tb/tb_branch_resolver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Branch resolution unit: decodes the RISC-V branch condition for an external comparator,
// resolves the outcome against the front-end prediction and redirects/flushes on a mispredict.
module branch_resolver #(
  parameter int width        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             br_valid_i,
  output logic             br_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [width-1:0] pc_i,
  input  logic [width-1:0] imm_i,
  input  logic             pred_taken_i,
  output logic [2:0]       cmp_op_o,
  input  logic [width-1:0] cmp_result_i,
  output logic             redirect_o,
  output logic [width-1:0] target_o,
  output logic             flush_o,
  output logic             illegal_o,
  output logic [15:0]      taken_cnt_o,
  output logic [15:0]      mispred_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_RESOLVE,
    S_FLUSH
  } state_t;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [width-1:0] INSN_BYTES = width'(4);

  state_t           state_q, state_d;
  logic [2:0]       f3_q;
  logic [width-1:0] pc_q;
  logic [width-1:0] imm_q;
  logic             pred_q;
  logic [FC_W-1:0]  flush_cnt_q;
  logic [width-1:0] target_q;
  logic [15:0]      taken_cnt_q;
  logic [15:0]      mispred_cnt_q;

  logic             legal;
  logic             taken;
  logic             in_resolve;
  logic             mispredict;
  logic [width-1:0] target_calc;
  logic [2:0]       op_decoded;

  // Only bit 0 of the comparator result carries the outcome.
  logic unused_cmp_bits;
  assign unused_cmp_bits = ^cmp_result_i[width-1:1];

  // funct3 010/011 have no branch encoding; 111 tells the comparator to idle.
  always_comb begin
    op_decoded = 3'b111;
    case (f3_q)
      3'b000:  op_decoded = 3'b000;
      3'b001:  op_decoded = 3'b001;
      3'b100:  op_decoded = 3'b101;
      3'b101:  op_decoded = 3'b110;
      3'b110:  op_decoded = 3'b100;
      3'b111:  op_decoded = 3'b011;
      default: op_decoded = 3'b111;
    endcase
  end

  assign legal       = (f3_q != 3'b010) && (f3_q != 3'b011);
  assign in_resolve  = (state_q == S_RESOLVE);
  assign taken       = legal && cmp_result_i[0];
  assign mispredict  = in_resolve && legal && (taken != pred_q);
  assign target_calc = pc_q + (taken ? imm_q : INSN_BYTES);

  // The redirect target is presented combinationally in the resolve cycle and
  // remembered afterwards so fetch sees a stable value between redirects.
  assign redirect_o    = mispredict;
  assign target_o      = mispredict ? target_calc : target_q;
  assign illegal_o     = in_resolve && !legal;
  assign br_ready_o    = (state_q == S_IDLE);
  assign flush_o       = (state_q == S_FLUSH);
  assign cmp_op_o      = ((state_q == S_CMP) || in_resolve) ? op_decoded : 3'b000;
  assign taken_cnt_o   = taken_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (br_valid_i) state_d = S_CMP;
      S_CMP:     state_d = S_RESOLVE;
      S_RESOLVE: state_d = (mispredict && (FLUSH_CYCLES > 0)) ? S_FLUSH : S_IDLE;
      S_FLUSH:   if (flush_cnt_q == '0) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      f3_q          <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      pred_q        <= 1'b0;
      flush_cnt_q   <= '0;
      target_q      <= '0;
      taken_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      if ((state_q == S_IDLE) && br_valid_i) begin
        f3_q   <= funct3_i;
        pc_q   <= pc_i;
        imm_q  <= imm_i;
        pred_q <= pred_taken_i;
      end

      if (in_resolve) begin
        flush_cnt_q <= FC_W'(FLUSH_CYCLES - 1);
      end else if ((state_q == S_FLUSH) && (flush_cnt_q != '0)) begin
        flush_cnt_q <= flush_cnt_q - 1'b1;
      end

      if (mispredict) begin
        target_q <= target_calc;
      end

      // Both event counters saturate rather than wrap.
      if (in_resolve && taken && (taken_cnt_q != 16'hFFFF)) begin
        taken_cnt_q <= taken_cnt_q + 16'd1;
      end
      if (mispredict && (mispred_cnt_q != 16'hFFFF)) begin
        mispred_cnt_q <= mispred_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: the driver queues hand-computed expectations,
// the monitor rebuilds each branch from DUT outputs and compares when it completes.
module tb_branch_resolver;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        br_valid_i;
  logic        br_ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic        pred_taken_i;
  logic [2:0]  cmp_op_o;
  logic [31:0] cmp_result_i;
  logic        redirect_o;
  logic [31:0] target_o;
  logic        flush_o;
  logic        illegal_o;
  logic [15:0] taken_cnt_o;
  logic [15:0] mispred_cnt_o;

  branch_resolver #(.width(32), .FLUSH_CYCLES(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .br_valid_i    (br_valid_i),
    .br_ready_o    (br_ready_o),
    .funct3_i      (funct3_i),
    .pc_i          (pc_i),
    .imm_i         (imm_i),
    .pred_taken_i  (pred_taken_i),
    .cmp_op_o      (cmp_op_o),
    .cmp_result_i  (cmp_result_i),
    .redirect_o    (redirect_o),
    .target_o      (target_o),
    .flush_o       (flush_o),
    .illegal_o     (illegal_o),
    .taken_cnt_o   (taken_cnt_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  cmp_op;
    int          redirects;
    logic [31:0] target;
    int          illegals;
    int          flushes;
    int          latency;
    logic [15:0] taken;
    logic [15:0] mispred;
  } txn_t;

  txn_t q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  logic busy     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [2:0] op, input int redir, input logic [31:0] tgt,
                              input int ill, input logic [15:0] tk, input logic [15:0] mp);
    txn_t t;
    t.cmp_op    = op;
    t.redirects = redir;
    t.target    = tgt;
    t.illegals  = ill;
    t.flushes   = (redir != 0) ? 2 : 0;
    t.latency   = (redir != 0) ? 5 : 3;
    t.taken     = tk;
    t.mispred   = mp;
    return t;
  endfunction

  // Waits for IDLE, presents one request and holds it until the accepting edge.
  task automatic send(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                      input logic pred, input logic res, input logic push, input txn_t e);
    int waits = 0;
    while (!br_ready_o && waits < 50) begin
      @(posedge clk_i);
      #1;
      waits++;
    end
    if (!br_ready_o) begin
      check("send_ready_timeout", 32'(br_ready_o), 32'd1);
      return;
    end
    if (push) q.push_back(e);
    funct3_i     = f3;
    pc_i         = pc;
    imm_i        = imm;
    pred_taken_i = pred;
    cmp_result_i = {31'b0, res};
    br_valid_i   = 1'b1;
    @(posedge clk_i);
    #1;
    br_valid_i = 1'b0;
  endtask

  // Monitor: observes mid-cycle, one transaction from acceptance to br_ready_o returning.
  initial begin
    txn_t obs;
    txn_t e;
    int   idx = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        busy = 1'b0;
        continue;
      end
      if (busy) begin
        obs.latency++;
        if (obs.latency == 1) obs.cmp_op = cmp_op_o;
        if (redirect_o) begin
          obs.redirects++;
          obs.target = target_o;
        end
        if (illegal_o) obs.illegals++;
        if (flush_o) obs.flushes++;
        if (br_ready_o) begin
          busy = 1'b0;
          if (obs.redirects == 0) obs.target = target_o;
          obs.taken   = taken_cnt_o;
          obs.mispred = mispred_cnt_o;
          if (q.size() == 0) begin
            check($sformatf("t%0d_unexpected_txn", idx), 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("t%0d_cmp_op", idx), 32'(obs.cmp_op), 32'(e.cmp_op));
            check($sformatf("t%0d_redirects", idx), 32'(obs.redirects), 32'(e.redirects));
            check($sformatf("t%0d_target", idx), obs.target, e.target);
            check($sformatf("t%0d_illegals", idx), 32'(obs.illegals), 32'(e.illegals));
            check($sformatf("t%0d_flush_cycles", idx), 32'(obs.flushes), 32'(e.flushes));
            check($sformatf("t%0d_latency", idx), 32'(obs.latency), 32'(e.latency));
            check($sformatf("t%0d_taken_cnt", idx), 32'(obs.taken), 32'(e.taken));
            check($sformatf("t%0d_mispred_cnt", idx), 32'(obs.mispred), 32'(e.mispred));
          end
          idx++;
        end else if (obs.latency > 20) begin
          busy = 1'b0;
          check($sformatf("t%0d_ready_timeout", idx), 32'(br_ready_o), 32'd1);
          idx++;
        end
      end
      if (!busy && br_valid_i && br_ready_o) begin
        busy          = 1'b1;
        obs.latency   = 0;
        obs.redirects = 0;
        obs.illegals  = 0;
        obs.flushes   = 0;
        obs.cmp_op    = 3'b000;
        obs.target    = '0;
      end
    end
  end

  initial begin
    int wait_cnt;
    txn_t none;
    none = mk(3'b000, 0, 32'h0, 0, 16'd0, 16'd0);
    rst_i        = 1'b1;
    br_valid_i   = 1'b0;
    funct3_i     = 3'b000;
    pc_i         = '0;
    imm_i        = '0;
    pred_taken_i = 1'b0;
    cmp_result_i = '0;

    repeat (2) @(negedge clk_i);
    check("rst_ready", 32'(br_ready_o), 32'd1);
    check("rst_redirect", 32'(redirect_o), 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_illegal", 32'(illegal_o), 32'd0);
    check("rst_cmp_op", 32'(cmp_op_o), 32'd0);
    check("rst_target", target_o, 32'd0);
    check("rst_taken_cnt", 32'(taken_cnt_o), 32'd0);
    check("rst_mispred_cnt", 32'(mispred_cnt_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // BEQ taken, predicted not taken: redirect to pc+imm
    send(3'b000, 32'h100, 32'h20, 1'b0, 1'b1, 1'b1, mk(3'b000, 1, 32'h120, 0, 16'd1, 16'd1));
    // BLTU not taken, predicted not taken: target holds previous redirect
    send(3'b110, 32'h300, 32'h40, 1'b0, 1'b0, 1'b1, mk(3'b100, 0, 32'h120, 0, 16'd1, 16'd1));
    // BGE not taken, predicted taken: redirect to pc+4
    send(3'b101, 32'h200, 32'h80, 1'b1, 1'b0, 1'b1, mk(3'b110, 1, 32'h204, 0, 16'd1, 16'd2));
    // funct3 010 with comparator high and prediction taken: illegal only
    send(3'b010, 32'h400, 32'h10, 1'b1, 1'b1, 1'b1, mk(3'b111, 0, 32'h204, 1, 16'd1, 16'd2));
    // BNE not taken at the top of the address space: pc+4 wraps to zero
    send(3'b001, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0, 1'b1, mk(3'b001, 1, 32'h0, 0, 16'd1, 16'd3));
    // BLT taken with negative offset
    send(3'b100, 32'h1000, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b1, mk(3'b101, 1, 32'hFF0, 0, 16'd2, 16'd4));
    // BGEU taken, predicted taken: counts taken, no redirect
    send(3'b111, 32'h500, 32'h100, 1'b1, 1'b1, 1'b1, mk(3'b011, 0, 32'hFF0, 0, 16'd3, 16'd4));
    // funct3 011 with comparator high: not counted as taken
    send(3'b011, 32'h600, 32'h10, 1'b0, 1'b1, 1'b1, mk(3'b111, 0, 32'hFF0, 1, 16'd3, 16'd4));

    // Mispredicted BLT, then reset while flushing
    send(3'b100, 32'h700, 32'h10, 1'b0, 1'b1, 1'b0, none);
    wait_cnt = 0;
    @(negedge clk_i);
    while (!flush_o && wait_cnt < 20) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    check("flush_reached", 32'(flush_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    check("async_rst_flush", 32'(flush_o), 32'd0);
    check("async_rst_ready", 32'(br_ready_o), 32'd1);
    check("async_rst_taken_cnt", 32'(taken_cnt_o), 32'd0);
    check("async_rst_mispred_cnt", 32'(mispred_cnt_o), 32'd0);
    check("async_rst_target", target_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Accepted on the first edge after release; counters restart from zero
    send(3'b111, 32'h40, 32'h4, 1'b1, 1'b1, 1'b1, mk(3'b011, 0, 32'h0, 0, 16'd1, 16'd0));
    check("post_rst_accepted", 32'(br_ready_o), 32'd0);

    wait_cnt = 0;
    while ((q.size() != 0 || busy) && wait_cnt < 50) begin
      @(posedge clk_i);
      wait_cnt++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
